// File: rtl/correlator_readout_pkg.sv
// -----------------------------------------------------------------------------
// correlator_readout_pkg
// Shared types and helpers for the correlator readout sequencer.
//   readout_state_t   : frame sequencer states (CHK is only reached when the
//                       READOUT_CHECKSUM_EN build option is defined)
//   SYNC_BYTE_DEFAULT : default frame header byte
//   payload_bytes()   : payload bytes in one frame
//   bytes_per_frame() : total bytes in one frame, header to checksum
//   index_width()     : width of a byte index over n bytes (minimum 1)
//   xor_fold()        : one step of the running XOR checksum
// -----------------------------------------------------------------------------
package correlator_readout_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEQ  = 3'd2,
    PAY  = 3'd3,
    CHK  = 3'd4
  } readout_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic int payload_bytes(input int word_width, input int num_words);
    return num_words * (word_width / 32'sd8);
  endfunction

  function automatic int bytes_per_frame(input int word_width, input int num_words,
                                         input bit with_checksum);
    return 32'sd2 + payload_bytes(word_width, num_words) + (with_checksum ? 32'sd1 : 32'sd0);
  endfunction

  function automatic int index_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/correlator_readout_sequencer_byte_select.sv
// -----------------------------------------------------------------------------
// readout_byte_select
// Combinational payload byte mux. Byte idx of the frame is byte
// (idx mod WORD_WIDTH/8) of word (idx / (WORD_WIDTH/8)); word 0 goes first and
// bytes within a word go out least significant first. Out-of-range indices
// return 8'h00.
// Ports:
//   buffer   in  NUM_WORDS*WORD_WIDTH  latched snapshot
//   idx      in  IDX_W                 payload byte index
//   byte_out out 8                     selected byte
// -----------------------------------------------------------------------------
module readout_byte_select
  import correlator_readout_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_WORDS  = 36,
  parameter int IDX_W      = index_width(payload_bytes(WORD_WIDTH, NUM_WORDS))
) (
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] buffer,
  input  logic [IDX_W-1:0]                idx,
  output logic [7:0]                      byte_out
);

  localparam int BPW    = WORD_WIDTH / 8;
  localparam int NBYTES = BPW * NUM_WORDS;

  logic [7:0] bytes_s [NBYTES];

  // Unpack the snapshot into a flat byte array in transmit order.
  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    for (genvar b = 0; b < BPW; b++) begin : g_byte
      assign bytes_s[w*BPW + b] = buffer[w*WORD_WIDTH + b*8 +: 8];
    end
  end

  // Select the indexed byte; indices past the payload read as zero.
  always_comb begin
    byte_out = 8'h00;
    if (32'(idx) < 32'(NBYTES)) begin
      byte_out = bytes_s[idx];
    end else begin
      byte_out = 8'h00;
    end
  end

endmodule

// File: rtl/correlator_readout_sequencer.sv
// -----------------------------------------------------------------------------
// correlator_readout_sequencer
// Frames one correlator/counter snapshot into a byte stream for the UART TX:
// sync byte, sequence number, payload bytes (word 0 first, little-endian within
// a word) and, when the READOUT_CHECKSUM_EN macro is defined, an 8-bit XOR
// checksum over the sequence and payload bytes. Without the macro the frame
// ends on the last payload byte and no checksum register exists.
// Ports:
//   clk               in   system clock
//   reset_correlator  in   asynchronous, active-high reset
//   frame_data        in   snapshot payload, word k at [k*WORD_WIDTH +: WORD_WIDTH]
//   frame_valid       in   one-cycle strobe: frame_data valid
//   transmit_enable   in   permits accepting new frames
//   tx_ready          in   UART TX can take a byte
//   tx_byte           out  byte to transmit (registered)
//   tx_valid          out  tx_byte valid (registered)
//   busy              out  frame latched or in transmission
//   overrun           out  sticky: frame_valid seen while busy
//   frame_seq         out  sequence number of the last accepted frame
// -----------------------------------------------------------------------------
module correlator_readout_sequencer
  import correlator_readout_pkg::*;
#(
  parameter int         WORD_WIDTH = 8,
  parameter int         NUM_WORDS  = 36,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter int         SEQ_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset_correlator,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] frame_data,
  input  logic                            frame_valid,
  input  logic                            transmit_enable,
  input  logic                            tx_ready,
  output logic [7:0]                      tx_byte,
  output logic                            tx_valid,
  output logic                            busy,
  output logic                            overrun,
  output logic [SEQ_WIDTH-1:0]            frame_seq
);

  localparam int             NBYTES   = payload_bytes(WORD_WIDTH, NUM_WORDS);
  localparam int             IDX_W    = index_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  readout_state_t                  state_r;
  logic [IDX_W-1:0]                idx_r;
  logic [NUM_WORDS*WORD_WIDTH-1:0] buffer_r;
  logic [IDX_W-1:0]                sel_idx_s;
  logic [7:0]                      sel_byte_s;
  logic                            xfer_s;
`ifdef READOUT_CHECKSUM_EN
  logic [7:0]                      chk_r;
`endif

  assign xfer_s = tx_valid & tx_ready;

  // tx_byte is registered, so the mux looks one byte ahead: payload byte 0
  // while the sequence byte is on the wire, otherwise the byte after idx_r.
  always_comb begin
    sel_idx_s = {IDX_W{1'b0}};
    if (state_r == SEQ) begin
      sel_idx_s = {IDX_W{1'b0}};
    end else begin
      sel_idx_s = idx_r + 1'b1;
    end
  end

  readout_byte_select #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_WORDS  (NUM_WORDS),
    .IDX_W      (IDX_W)
  ) u_byte_select (
    .buffer   (buffer_r),
    .idx      (sel_idx_s),
    .byte_out (sel_byte_s)
  );

  // Frame sequencer: accept, header, sequence, payload, optional checksum.
  always_ff @(posedge clk or posedge reset_correlator) begin
    if (reset_correlator) begin
      state_r   <= IDLE;
      tx_valid  <= 1'b0;
      tx_byte   <= 8'h00;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_seq <= {SEQ_WIDTH{1'b1}};
      idx_r     <= {IDX_W{1'b0}};
      buffer_r  <= {(NUM_WORDS*WORD_WIDTH){1'b0}};
`ifdef READOUT_CHECKSUM_EN
      chk_r     <= 8'h00;
`endif
    end else begin
      // A frame offered while one is held is dropped; remember that it happened.
      if (frame_valid && busy) begin
        overrun <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          if (frame_valid && transmit_enable) begin
            buffer_r  <= frame_data;
            frame_seq <= frame_seq + 1'b1;
            idx_r     <= {IDX_W{1'b0}};
            state_r   <= HDR;
            tx_valid  <= 1'b1;
            tx_byte   <= SYNC_BYTE;
            busy      <= 1'b1;
`ifdef READOUT_CHECKSUM_EN
            chk_r     <= 8'h00;
`endif
          end
        end

        HDR: begin
          if (xfer_s) begin
            state_r <= SEQ;
            tx_byte <= 8'(frame_seq);
          end
        end

        SEQ: begin
          if (xfer_s) begin
            state_r <= PAY;
            idx_r   <= {IDX_W{1'b0}};
            tx_byte <= sel_byte_s;
`ifdef READOUT_CHECKSUM_EN
            chk_r   <= xor_fold(chk_r, tx_byte);
`endif
          end
        end

        PAY: begin
          if (xfer_s) begin
`ifdef READOUT_CHECKSUM_EN
            chk_r <= xor_fold(chk_r, tx_byte);
`endif
            if (idx_r == LAST_IDX) begin
`ifdef READOUT_CHECKSUM_EN
              // The checksum byte includes the payload byte leaving now.
              state_r <= CHK;
              tx_byte <= xor_fold(chk_r, tx_byte);
`else
              state_r  <= IDLE;
              tx_valid <= 1'b0;
              tx_byte  <= 8'h00;
              busy     <= 1'b0;
`endif
            end else begin
              idx_r   <= idx_r + 1'b1;
              tx_byte <= sel_byte_s;
            end
          end
        end

`ifdef READOUT_CHECKSUM_EN
        CHK: begin
          if (xfer_s) begin
            state_r  <= IDLE;
            tx_valid <= 1'b0;
            tx_byte  <= 8'h00;
            busy     <= 1'b0;
          end
        end
`endif

        default: begin
          state_r  <= IDLE;
          tx_valid <= 1'b0;
          tx_byte  <= 8'h00;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_correlator_readout_sequencer.sv
// -----------------------------------------------------------------------------
// tb_correlator_readout_sequencer
// Self-checking bench for correlator_readout_sequencer with NUM_WORDS=4,
// WORD_WIDTH=16. Expected bytes are queued when a frame is driven and popped
// by a monitor on every accepted transfer. Honours READOUT_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_correlator_readout_sequencer;

  localparam int WW = 16;
  localparam int NW = 4;
`ifdef READOUT_CHECKSUM_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic        clk = 1'b0;
  logic        reset_correlator = 1'b1;
  logic [63:0] frame_data = 64'h0;
  logic        frame_valid = 1'b0;
  logic        transmit_enable = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        busy;
  logic        overrun;
  logic [7:0]  frame_seq;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_seq = 8'hFF;
  logic [7:0]  exp_b;
  int          stall_mode = 0;
  int          xfer_cnt = 0;
  bit          mon_en = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [7:0]  prev_byte = 8'h00;

  correlator_readout_sequencer #(
    .WORD_WIDTH (WW),
    .NUM_WORDS  (NW),
    .SYNC_BYTE  (8'hA5),
    .SEQ_WIDTH  (8)
  ) dut (
    .clk              (clk),
    .reset_correlator (reset_correlator),
    .frame_data       (frame_data),
    .frame_valid      (frame_valid),
    .transmit_enable  (transmit_enable),
    .tx_ready         (tx_ready),
    .tx_byte          (tx_byte),
    .tx_valid         (tx_valid),
    .busy             (busy),
    .overrun          (overrun),
    .frame_seq        (frame_seq)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // tx_ready: held high, or high one cycle in three when stalling.
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode != 0) tx_ready = ((cyc % 3) == 2);
      else tx_ready = 1'b1;
      cyc++;
    end
  end

  // Monitor: pop and compare on each transfer; check stall stability.
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_valid = 1'b0;
      end else begin
        if (tx_valid) begin
          if (prev_valid && !prev_ready) check8("stall_hold", tx_byte, prev_byte);
          if (tx_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_byte: got %02h expected none at %0t", tx_byte, $time);
            end else begin
              exp_b = exp_q.pop_front();
              check8("byte", tx_byte, exp_b);
            end
            xfer_cnt++;
          end
        end
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_byte  = tx_byte;
      end
    end
  end

  task automatic drive_frame(input logic [63:0] d, input logic en);
    @(posedge clk);
    #1;
    frame_data      = d;
    frame_valid     = 1'b1;
    transmit_enable = en;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
  endtask

  // Model: queue the frame the DUT should emit, then drive it.
  task automatic send_frame(input logic [63:0] d, input logic en, input bit accept);
    logic [15:0] w;
    logic [7:0]  chk;
    if (accept) begin
      exp_seq = exp_seq + 8'd1;
      exp_q.push_back(8'hA5);
      exp_q.push_back(exp_seq);
      chk = exp_seq;
      for (int k = 0; k < NW; k++) begin
        w = d[16*k +: 16];
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        chk = chk ^ w[7:0] ^ w[15:8];
      end
`ifdef READOUT_CHECKSUM_EN
      exp_q.push_back(chk);
`endif
    end
    drive_frame(d, en);
  endtask

  task automatic wait_idle(output int busy_cycles);
    bit done;
    done = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #2;
      if (busy) busy_cycles++;
      if (!busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle", busy, exp_q.size());
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic        en;
    int          stall;
    logic [7:0]  seq_after;
  } vec_t;

  initial begin
    vec_t        vecs [4];
    int          bc;
    int          start_cnt;
    logic [7:0]  kb;
    logic [63:0] d;

    vecs[0] = '{64'h7788_5566_3344_1122, 1'b1, 1, 8'h01};
    vecs[1] = '{64'hDEAD_BEEF_0BAD_F00D, 1'b0, 0, 8'h01};
    vecs[2] = '{64'h0123_4567_89AB_CDEF, 1'b1, 1, 8'h02};
    vecs[3] = '{64'hFFFF_0000_A5A5_5A5A, 1'b1, 0, 8'h03};

    // Reset state.
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check8("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    check8("rst_tx_byte", tx_byte, 8'h00);
    check8("rst_busy", {7'd0, busy}, 8'h00);
    check8("rst_overrun", {7'd0, overrun}, 8'h00);
    check8("rst_frame_seq", frame_seq, 8'hFF);
    reset_correlator = 1'b0;

    // Basic frame with literal expected bytes, tx_ready held high.
    exp_seq = 8'h00;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00);
    exp_q.push_back(8'h22); exp_q.push_back(8'h11);
    exp_q.push_back(8'h44); exp_q.push_back(8'h33);
    exp_q.push_back(8'h66); exp_q.push_back(8'h55);
    exp_q.push_back(8'h88); exp_q.push_back(8'h77);
`ifdef READOUT_CHECKSUM_EN
    exp_q.push_back(8'h88);
`endif
    drive_frame(64'h7788_5566_3344_1122, 1'b1);
    wait_idle(bc);
    check8("basic_busy_cycles", 8'(bc), 8'(FLEN));
    check8("basic_frame_seq", frame_seq, 8'h00);
    check8("basic_busy_clear", {7'd0, busy}, 8'h00);

    // Table: backpressure, gated frame, further data patterns.
    for (int i = 0; i < 4; i++) begin
      stall_mode = vecs[i].stall;
      send_frame(vecs[i].data, vecs[i].en, vecs[i].en);
      repeat (3) @(posedge clk);
      wait_idle(bc);
      check8("vec_frame_seq", frame_seq, vecs[i].seq_after);
      check8("vec_busy", {7'd0, busy}, 8'h00);
      check8("vec_overrun", {7'd0, overrun}, 8'h00);
    end
    stall_mode = 0;

    // Overrun: second frame_valid while the first is in PAY.
    send_frame(64'h1111_2222_3333_4444, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    frame_data  = 64'h9999_8888_7777_6666;
    frame_valid = 1'b1;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    wait_idle(bc);
    check8("ovr_overrun", {7'd0, overrun}, 8'h01);
    check8("ovr_frame_seq", frame_seq, 8'h04);
    send_frame(64'h0F0F_F0F0_1234_5678, 1'b1, 1'b1);
    wait_idle(bc);
    check8("ovr_next_seq", frame_seq, 8'h05);
    check8("ovr_sticky", {7'd0, overrun}, 8'h01);

    // Reset during PAY byte 3.
    start_cnt = xfer_cnt;
    send_frame(64'hCAFE_BABE_F00D_D00D, 1'b1, 1'b1);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #2;
      if (xfer_cnt - start_cnt >= 6) break;
    end
    check8("mid_pay3_byte", tx_byte, 8'hF0);
    reset_correlator = 1'b1;
    mon_en = 1'b0;
    #1;
    check8("mid_rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    check8("mid_rst_busy", {7'd0, busy}, 8'h00);
    exp_q.delete();
    exp_seq = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_correlator = 1'b0;
    check8("mid_frame_seq", frame_seq, 8'hFF);
    check8("mid_overrun", {7'd0, overrun}, 8'h00);
    check8("mid_tx_valid", {7'd0, tx_valid}, 8'h00);
    mon_en = 1'b1;
    send_frame(64'h0102_0304_0506_0708, 1'b1, 1'b1);
    wait_idle(bc);
    check8("post_rst_seq", frame_seq, 8'h00);

    // Sequence wrap: 256 more frames, 01..FF then 00.
    for (int k = 0; k < 256; k++) begin
      kb = k[7:0];
      d  = {4{kb, ~kb}};
      send_frame(d, 1'b1, 1'b1);
      wait_idle(bc);
      if (k == 254) check8("wrap_ff", frame_seq, 8'hFF);
    end
    check8("wrap_00", frame_seq, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
